// File: rtl/connector_pkg.sv
// -----------------------------------------------------------------------------
// connector_pkg
// Shared types for the commit-port to trace-encoder connector.
//   cf_t          resolved control-flow type of a retired instruction
//   commit_pkt_t  one retired-instruction packet as seen by the itype detector
// Default sizing constants are provided for the modules that use them.
// -----------------------------------------------------------------------------
package connector_pkg;

  localparam int unsigned XLEN                = 64;
  localparam int unsigned DEF_NR_COMMIT_PORTS = 2;
  localparam int unsigned DEF_DEPTH           = 8;
  localparam int unsigned DROP_CNT_W          = 16;

  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;

  typedef struct packed {
    logic            ex_valid;
    logic            interrupt;
    logic            eret;
    cf_t             branch_type;
    logic            taken;
    logic            compressed;
    logic [XLEN-1:0] iaddr;
  } commit_pkt_t;

endpackage

// File: rtl/commit_fifo_mw.sv
// -----------------------------------------------------------------------------
// commit_fifo_mw
// Multi-write / single-read circular buffer of commit packets.
// Up to NR_WR packets are written per cycle from a compacted write bus: slots
// 0 .. wr_cnt_i-1 of wr_data_i are valid and are stored in that order starting
// at the write pointer. One packet is read per cycle.
// The caller guarantees wr_cnt_i never exceeds the free space and that pop_i
// is only asserted when the buffer is non-empty.
// Ports
//   clk_i, reset_i   clock, asynchronous active-high reset
//   wr_cnt_i         number of compacted packets to store this cycle
//   wr_data_i        compacted packets, slot 0 oldest
//   pop_i            remove the oldest entry
//   rd_data_o        oldest entry ('0 when empty)
//   count_o          number of buffered entries
// -----------------------------------------------------------------------------
module commit_fifo_mw
  import connector_pkg::*;
#(
  parameter int unsigned NR_WR = DEF_NR_COMMIT_PORTS,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [$clog2(DEPTH+1)-1:0]   wr_cnt_i,
  input  commit_pkt_t [NR_WR-1:0]      wr_data_i,
  input  logic                         pop_i,
  output commit_pkt_t                  rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  commit_pkt_t mem_q [DEPTH];

  // Pointers are exactly log2(DEPTH) bits, so the adds wrap modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_cnt_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + wr_cnt_i - CNT_W'(pop_i);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples its pre-edge value; combinational blocks use blocking.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; entries are only observable once count_q
  // covers them, and the output is forced to '0 while empty.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_WR; i++) begin
      if (CNT_W'(i) < wr_cnt_i) begin
        mem_q[wr_ptr_q + PTR_W'(i)] <= wr_data_i[i];
      end
    end
  end

  assign rd_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;

endmodule

// File: rtl/commit_serializer.sv
// -----------------------------------------------------------------------------
// commit_serializer
// Captures up to NR_COMMIT_PORTS retired-instruction packets per cycle from
// the core's commit ports, buffers them in program order and presents them one
// per cycle on a valid/ready interface for the single-lane itype detector.
// The core cannot be stalled: packets that do not fit are dropped, counted in
// a saturating counter and flagged by a sticky overflow bit.
// Ports
//   clk_i, reset_i       clock, asynchronous active-high reset
//   commit_valid_i       per lane: instruction retires (lane 0 oldest)
//   commit_ex_valid_i    per lane: exception
//   interrupt_i          per lane: exception is an interrupt
//   eret_i               per lane: xRET
//   branch_type_i        per lane: resolved control-flow type
//   branch_taken_i       per lane: branch taken
//   iaddr_i              per lane: instruction address
//   compressed_i         per lane: 16-bit instruction
//   pkt_valid_o, pkt_o   oldest buffered packet
//   pkt_ready_i          consumer takes pkt_o this cycle
//   count_o              buffered entries
//   overflow_o           sticky: a packet was dropped
//   clear_overflow_i     clears overflow_o and drop_cnt_o
//   drop_cnt_o           saturating dropped-packet count
// -----------------------------------------------------------------------------
module commit_serializer
  import connector_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = DEF_NR_COMMIT_PORTS,
  parameter int unsigned DEPTH           = DEF_DEPTH
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [NR_COMMIT_PORTS-1:0]            commit_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]            commit_ex_valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]            interrupt_i,
  input  logic [NR_COMMIT_PORTS-1:0]            eret_i,
  input  cf_t  [NR_COMMIT_PORTS-1:0]            branch_type_i,
  input  logic [NR_COMMIT_PORTS-1:0]            branch_taken_i,
  input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]  iaddr_i,
  input  logic [NR_COMMIT_PORTS-1:0]            compressed_i,
  output logic                                  pkt_valid_o,
  output commit_pkt_t                           pkt_o,
  input  logic                                  pkt_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]            count_o,
  output logic                                  overflow_o,
  input  logic                                  clear_overflow_i,
  output logic [DROP_CNT_W-1:0]                 drop_cnt_o
);

  localparam int unsigned CNT_W  = $clog2(DEPTH+1);
  localparam int unsigned DROP_W = $clog2(NR_COMMIT_PORTS+1);

  commit_pkt_t [NR_COMMIT_PORTS-1:0] lane_pkt;
  commit_pkt_t [NR_COMMIT_PORTS-1:0] wr_data;
  logic [CNT_W-1:0]                  count;
  logic [CNT_W-1:0]                  space;
  logic [CNT_W-1:0]                  n_acc;
  logic [DROP_W-1:0]                 n_drop;
  logic                              pop;

  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]   drop_sum;

  // ---------------------------------------------------------------------------
  // Per-lane packet assembly: fields are stored unchanged.
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_pkt = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      lane_pkt[k].ex_valid    = commit_ex_valid_i[k];
      lane_pkt[k].interrupt   = interrupt_i[k];
      lane_pkt[k].eret        = eret_i[k];
      lane_pkt[k].branch_type = branch_type_i[k];
      lane_pkt[k].taken       = branch_taken_i[k];
      lane_pkt[k].compressed  = compressed_i[k];
      lane_pkt[k].iaddr       = iaddr_i[k];
    end
  end

  assign pkt_valid_o = (count != '0);
  assign pop         = pkt_valid_o & pkt_ready_i;

  // A pop in the same cycle frees its slot for an incoming packet, so full
  // plus pop still accepts one lane. pop implies count > 0, so space <= DEPTH.
  assign space = CNT_W'(DEPTH) - count + CNT_W'(pop);

  // ---------------------------------------------------------------------------
  // Lane compaction: walk lanes oldest first; each valid lane takes the next
  // compacted slot while space remains, later lanes are dropped. Lanes with
  // commit_valid_i low are skipped regardless of their exception bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_data = '0;
    n_acc   = '0;
    n_drop  = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (commit_valid_i[k]) begin
        if (n_acc < space) begin
          for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
            if (CNT_W'(j) == n_acc) begin
              wr_data[j] = lane_pkt[k];
            end
          end
          n_acc = n_acc + CNT_W'(1);
        end else begin
          n_drop = n_drop + DROP_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow bookkeeping. A clear restarts the count from zero, and a drop in
  // the same cycle is applied on top of it, so set wins over clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = '0;
    if (clear_overflow_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
    if (n_drop != '0) begin
      overflow_d = 1'b1;
      drop_sum   = {1'b0, drop_cnt_d} + (DROP_CNT_W+1)'(n_drop);
      drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  commit_fifo_mw #(
    .NR_WR (NR_COMMIT_PORTS),
    .DEPTH (DEPTH)
  ) i_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_cnt_i  (n_acc),
    .wr_data_i (wr_data),
    .pop_i     (pop),
    .rd_data_o (pkt_o),
    .count_o   (count)
  );

  assign count_o    = count;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_commit_serializer.sv
module tb_commit_serializer;
  import connector_pkg::*;

  logic              clk_i;
  logic              reset_i;
  logic [1:0]        commit_valid_i;
  logic [1:0]        commit_ex_valid_i;
  logic [1:0]        interrupt_i;
  logic [1:0]        eret_i;
  cf_t  [1:0]        branch_type_i;
  logic [1:0]        branch_taken_i;
  logic [1:0][63:0]  iaddr_i;
  logic [1:0]        compressed_i;
  logic              pkt_valid_o;
  commit_pkt_t       pkt_o;
  logic              pkt_ready_i;
  logic [3:0]        count_o;
  logic              overflow_o;
  logic              clear_overflow_i;
  logic [15:0]       drop_cnt_o;

  int checks = 0;
  int errors = 0;

  commit_serializer #(.NR_COMMIT_PORTS(2), .DEPTH(8)) dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .commit_valid_i    (commit_valid_i),
    .commit_ex_valid_i (commit_ex_valid_i),
    .interrupt_i       (interrupt_i),
    .eret_i            (eret_i),
    .branch_type_i     (branch_type_i),
    .branch_taken_i    (branch_taken_i),
    .iaddr_i           (iaddr_i),
    .compressed_i      (compressed_i),
    .pkt_valid_o       (pkt_valid_o),
    .pkt_o             (pkt_o),
    .pkt_ready_i       (pkt_ready_i),
    .count_o           (count_o),
    .overflow_o        (overflow_o),
    .clear_overflow_i  (clear_overflow_i),
    .drop_cnt_o        (drop_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive one cycle of stimulus at a falling edge; returns at the next falling
  // edge, after the rising edge has consumed it.
  task automatic step(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] a1,
                      input logic rdy, input logic clr);
    commit_valid_i   = v;
    iaddr_i[0]       = a0;
    iaddr_i[1]       = a1;
    pkt_ready_i      = rdy;
    clear_overflow_i = clr;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    if (pkt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pkt_valid_o); end
    checks++;
    if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
    checks++;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow_o); end
    checks++;
    if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
    checks++;
    if (pkt_o !== '0) begin errors++; $display("FAIL reset_pkt got %h want 0", pkt_o); end
    checks++;
  endtask

  task automatic test_single();
    step(2'b01, 64'h8000_0000, 64'h0, 1'b1, 1'b0);
    if (pkt_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", pkt_valid_o); end
    checks++;
    if (pkt_o.iaddr !== 64'h8000_0000) begin errors++; $display("FAIL single_iaddr got %h want 80000000", pkt_o.iaddr); end
    checks++;
    if (count_o !== 4'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", count_o); end
    checks++;
    step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    if (count_o !== 4'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", count_o); end
    checks++;
    if (pkt_valid_o !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", pkt_valid_o); end
    checks++;
  endtask

  task automatic test_two_lanes();
    step(2'b11, 64'h100, 64'h104, 1'b0, 1'b0);
    if (count_o !== 4'd2) begin errors++; $display("FAIL two_count got %0d want 2", count_o); end
    checks++;
    if (pkt_o.iaddr !== 64'h100) begin errors++; $display("FAIL two_first got %h want 100", pkt_o.iaddr); end
    checks++;
    step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    if (pkt_o.iaddr !== 64'h104) begin errors++; $display("FAIL two_second got %h want 104", pkt_o.iaddr); end
    checks++;
    if (count_o !== 4'd1) begin errors++; $display("FAIL two_count1 got %0d want 1", count_o); end
    checks++;
    step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    if (count_o !== 4'd0) begin errors++; $display("FAIL two_drain got %0d want 0", count_o); end
    checks++;
  endtask

  task automatic test_lane1_only();
    // Lane 0 carries an exception but does not retire: it must be ignored.
    commit_ex_valid_i = 2'b01;
    eret_i            = 2'b10;
    branch_type_i[1]  = Return;
    step(2'b10, 64'hDEAD, 64'h200, 1'b0, 1'b0);
    commit_ex_valid_i = 2'b00;
    eret_i            = 2'b00;
    branch_type_i[1]  = NoCF;
    if (count_o !== 4'd1) begin errors++; $display("FAIL lane1_count got %0d want 1", count_o); end
    checks++;
    if (pkt_o.iaddr !== 64'h200) begin errors++; $display("FAIL lane1_iaddr got %h want 200", pkt_o.iaddr); end
    checks++;
    if (pkt_o.eret !== 1'b1) begin errors++; $display("FAIL lane1_eret got %b want 1", pkt_o.eret); end
    checks++;
    if (pkt_o.ex_valid !== 1'b0) begin errors++; $display("FAIL lane1_ex got %b want 0", pkt_o.ex_valid); end
    checks++;
    if (pkt_o.branch_type !== Return) begin errors++; $display("FAIL lane1_cf got %0d want %0d", pkt_o.branch_type, Return); end
    checks++;
    step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    if (count_o !== 4'd0) begin errors++; $display("FAIL lane1_drain got %0d want 0", count_o); end
    checks++;
  endtask

  task automatic test_overflow();
    logic [63:0] exp_seq [8];
    exp_seq = '{64'h1002, 64'h1003, 64'h1004, 64'h1005, 64'h1006, 64'h300, 64'h400, 64'h404};
    step(2'b11, 64'h1000, 64'h1001, 1'b0, 1'b0);
    step(2'b11, 64'h1002, 64'h1003, 1'b0, 1'b0);
    step(2'b11, 64'h1004, 64'h1005, 1'b0, 1'b0);
    step(2'b01, 64'h1006, 64'h0,    1'b0, 1'b0);
    if (count_o !== 4'd7) begin errors++; $display("FAIL ovf_fill got %0d want 7", count_o); end
    checks++;
    step(2'b11, 64'h300, 64'h304, 1'b0, 1'b0);
    if (count_o !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d want 8", count_o); end
    checks++;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow_o); end
    checks++;
    if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL ovf_drop got %0d want 1", drop_cnt_o); end
    checks++;
    step(2'b00, 64'h0, 64'h0, 1'b1, 1'b1);
    if (count_o !== 4'd7 || overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL ovf_clear got count=%0d ovf=%b drop=%0d want 7 0 0", count_o, overflow_o, drop_cnt_o);
    end
    checks++;
    step(2'b11, 64'h400, 64'h404, 1'b1, 1'b0);
    if (count_o !== 4'd8 || overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL ovf_popfree got count=%0d ovf=%b drop=%0d want 8 0 0", count_o, overflow_o, drop_cnt_o);
    end
    checks++;
    for (int i = 0; i < 8; i++) begin
      if (pkt_valid_o !== 1'b1 || pkt_o.iaddr !== exp_seq[i]) begin
        errors++;
        $display("FAIL ovf_order[%0d] got valid=%b iaddr=%h want 1 %h", i, pkt_valid_o, pkt_o.iaddr, exp_seq[i]);
      end
      checks++;
      step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    end
    if (count_o !== 4'd0) begin errors++; $display("FAIL ovf_drain got %0d want 0", count_o); end
    checks++;
  endtask

  task automatic test_random();
    logic [63:0] model_q [$];
    logic [63:0] next_addr;
    logic [1:0]  v;
    logic        rdy;
    logic        exp_ovf;
    int          exp_drop;
    int          space;
    int          nv;
    next_addr = 64'h4000;
    exp_ovf   = 1'b0;
    exp_drop  = 0;
    for (int c = 0; c < 30; c++) begin
      if (count_o !== 4'(model_q.size())) begin
        errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, count_o, model_q.size());
      end
      checks++;
      if (model_q.size() > 0) begin
        if (pkt_o.iaddr !== model_q[0]) begin
          errors++; $display("FAIL rnd_iaddr[%0d] got %h want %h", c, pkt_o.iaddr, model_q[0]);
        end
        checks++;
      end
      if (overflow_o !== exp_ovf || drop_cnt_o !== 16'(exp_drop)) begin
        errors++; $display("FAIL rnd_ovf[%0d] got %b/%0d want %b/%0d", c, overflow_o, drop_cnt_o, exp_ovf, exp_drop);
      end
      checks++;
      nv  = int'($urandom_range(0, 2));
      v   = (nv == 2) ? 2'b11 : (nv == 1) ? (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01) : 2'b00;
      rdy = 1'($urandom_range(0, 1));
      space = 8 - model_q.size();
      if (model_q.size() > 0 && rdy) begin
        void'(model_q.pop_front());
        space++;
      end
      for (int k = 0; k < 2; k++) begin
        if (v[k]) begin
          if (space > 0) begin
            model_q.push_back(next_addr + 64'(4 * k));
            space--;
          end else begin
            exp_drop++;
            exp_ovf = 1'b1;
          end
        end
      end
      step(v, next_addr, next_addr + 64'd4, rdy, 1'b0);
      next_addr = next_addr + 64'h10;
    end
    for (int c = 0; c < 12 && model_q.size() > 0; c++) begin
      if (pkt_o.iaddr !== model_q[0]) begin
        errors++; $display("FAIL rnd_drain[%0d] got %h want %h", c, pkt_o.iaddr, model_q[0]);
      end
      checks++;
      void'(model_q.pop_front());
      step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    end
    if (count_o !== 4'd0) begin errors++; $display("FAIL rnd_empty got %0d want 0", count_o); end
    checks++;
    step(2'b00, 64'h0, 64'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) step(2'b11, 64'h500 + 64'(i * 8), 64'h504 + 64'(i * 8), 1'b0, 1'b0);
    step(2'b11, 64'h600, 64'h604, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
    step(2'b00, 64'h0, 64'h0, 1'b0, 1'b0);
    if (count_o !== 4'd5 || overflow_o !== 1'b1 || drop_cnt_o !== 16'd2) begin
      errors++; $display("FAIL mid_setup got count=%0d ovf=%b drop=%0d want 5 1 2", count_o, overflow_o, drop_cnt_o);
    end
    checks++;
    #2;
    reset_i = 1'b1;
    #1;
    test_reset();
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic test_clear_vs_drop();
    for (int i = 0; i < 4; i++) step(2'b11, 64'h700 + 64'(i * 8), 64'h704 + 64'(i * 8), 1'b0, 1'b0);
    step(2'b11, 64'h800, 64'h804, 1'b0, 1'b0);
    if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL clr_pre got %0d want 2", drop_cnt_o); end
    checks++;
    step(2'b11, 64'h900, 64'h904, 1'b1, 1'b1);
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL clr_set_wins got %b want 1", overflow_o); end
    checks++;
    if (drop_cnt_o !== 16'd1) begin errors++; $display("FAIL clr_drop got %0d want 1", drop_cnt_o); end
    checks++;
    if (count_o !== 4'd8) begin errors++; $display("FAIL clr_count got %0d want 8", count_o); end
    checks++;
  endtask

  initial begin
    reset_i           = 1'b1;
    commit_valid_i    = '0;
    commit_ex_valid_i = '0;
    interrupt_i       = '0;
    eret_i            = '0;
    branch_type_i     = {NoCF, NoCF};
    branch_taken_i    = '0;
    iaddr_i           = '0;
    compressed_i      = '0;
    pkt_ready_i       = 1'b0;
    clear_overflow_i  = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    test_reset();
    reset_i = 1'b0;
    @(negedge clk_i);
    test_single();
    test_two_lanes();
    test_lane1_only();
    test_overflow();
    test_random();
    test_reset_midstream();
    test_clear_vs_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
